// File: rtl/ram_port_arbiter_if.sv
// Client, RAM and status signals of the RAM port arbiter, bundled so the
// arbiter and its environment share one connection.
interface ram_port_arbiter_if;
  logic        ld_we;
  logic [24:0] ld_address;
  logic [15:0] ld_data;
  logic        ld_op_begun;
  logic        ld_done;

  logic        a_rd;
  logic [24:0] a_address;
  logic        a_op_begun;
  logic [15:0] a_data;
  logic        a_valid;

  logic        v_rd;
  logic [24:0] v_address;
  logic        v_op_begun;
  logic [15:0] v_data;
  logic        v_valid;

  logic        mem_req;
  logic        mem_we;
  logic [24:0] mem_address;
  logic [15:0] mem_wdata;
  logic        mem_op_begun;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;

  logic [1:0]  owner;
  logic        rd_timeout_err;

  modport master (
    input  ld_we, ld_address, ld_data, ld_done,
    input  a_rd, a_address, v_rd, v_address,
    input  mem_op_begun, mem_rdata, mem_rvalid,
    output ld_op_begun, a_op_begun, a_data, a_valid,
    output v_op_begun, v_data, v_valid,
    output mem_req, mem_we, mem_address, mem_wdata,
    output owner, rd_timeout_err
  );

  modport slave (
    output ld_we, ld_address, ld_data, ld_done,
    output a_rd, a_address, v_rd, v_address,
    output mem_op_begun, mem_rdata, mem_rvalid,
    input  ld_op_begun, a_op_begun, a_data, a_valid,
    input  v_op_begun, v_data, v_valid,
    input  mem_req, mem_we, mem_address, mem_wdata,
    input  owner, rd_timeout_err
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Shares one RAM port between a boot loader (writes until ld_done) and two
// read clients, audio and video, with video starvation protection.
module ram_port_arbiter #(
  parameter int MAX_WAIT   = 8,
  parameter int RD_TIMEOUT = 255
) (
  input logic                clk50,
  input logic                reset_n,
  ram_port_arbiter_if.master bus
);
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRANT     = 2'd1,
    WAIT_DATA = 2'd2
  } state_t;

  localparam logic [1:0] OWN_NONE   = 2'd0;
  localparam logic [1:0] OWN_LD     = 2'd1;
  localparam logic [1:0] OWN_A      = 2'd2;
  localparam logic [1:0] OWN_V      = 2'd3;
  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);
  localparam logic [7:0] TMO_LAST   = 8'(RD_TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic [1:0]  owner_reg, owner_next;
  logic        mem_req_reg, mem_req_next;
  logic        mem_we_reg, mem_we_next;
  logic [24:0] mem_address_reg, mem_address_next;
  logic [15:0] mem_wdata_reg, mem_wdata_next;
  logic [3:0]  v_wait_reg, v_wait_next;
  logic [7:0]  tmo_cnt_reg, tmo_cnt_next;
  logic        err_reg, err_next;
  logic        rd_capture;
  logic        v_starved;
  logic        grant_ld, grant_a, grant_v;

  // The loader owns the RAM exclusively until it reports done; afterwards
  // audio wins unless video has waited the full starvation limit.
  assign v_starved = (v_wait_reg == WAIT_LIMIT);
  assign grant_ld  = !bus.ld_done && bus.ld_we;
  assign grant_v   = bus.ld_done && bus.v_rd && (!bus.a_rd || v_starved);
  assign grant_a   = bus.ld_done && bus.a_rd && !grant_v;

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      owner_reg       <= OWN_NONE;
      mem_req_reg     <= 1'b0;
      mem_we_reg      <= 1'b0;
      mem_address_reg <= '0;
      mem_wdata_reg   <= '0;
      v_wait_reg      <= '0;
      tmo_cnt_reg     <= '0;
      err_reg         <= 1'b0;
    end else begin
      state_reg       <= state_next;
      owner_reg       <= owner_next;
      mem_req_reg     <= mem_req_next;
      mem_we_reg      <= mem_we_next;
      mem_address_reg <= mem_address_next;
      mem_wdata_reg   <= mem_wdata_next;
      v_wait_reg      <= v_wait_next;
      tmo_cnt_reg     <= tmo_cnt_next;
      err_reg         <= err_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    owner_next       = owner_reg;
    mem_req_next     = mem_req_reg;
    mem_we_next      = mem_we_reg;
    mem_address_next = mem_address_reg;
    mem_wdata_next   = mem_wdata_reg;
    tmo_cnt_next     = tmo_cnt_reg;
    err_next         = err_reg;
    rd_capture       = 1'b0;
    v_wait_next      = v_wait_reg;

    if (bus.v_rd && (owner_reg != OWN_V) && !v_starved) begin
      v_wait_next = v_wait_reg + 4'd1;
    end

    unique case (state_reg)
      IDLE: begin
        if (grant_ld || grant_a || grant_v) begin
          state_next   = GRANT;
          mem_req_next = 1'b1;
        end
        if (grant_ld) begin
          owner_next       = OWN_LD;
          mem_we_next      = 1'b1;
          mem_address_next = bus.ld_address;
          mem_wdata_next   = bus.ld_data;
        end else if (grant_v) begin
          owner_next       = OWN_V;
          mem_we_next      = 1'b0;
          mem_address_next = bus.v_address;
          mem_wdata_next   = '0;
          v_wait_next      = '0;
        end else if (grant_a) begin
          owner_next       = OWN_A;
          mem_we_next      = 1'b0;
          mem_address_next = bus.a_address;
          mem_wdata_next   = '0;
        end
      end

      // Once granted the operation runs to completion regardless of the
      // client request or ld_done changing underneath it.
      GRANT: begin
        if (bus.mem_op_begun) begin
          mem_req_next = 1'b0;
          if (mem_we_reg) begin
            state_next = IDLE;
            owner_next = OWN_NONE;
          end else begin
            state_next   = WAIT_DATA;
            tmo_cnt_next = '0;
          end
        end
      end

      WAIT_DATA: begin
        if (bus.mem_rvalid) begin
          rd_capture = 1'b1;
          state_next = IDLE;
          owner_next = OWN_NONE;
        end else if (tmo_cnt_reg == TMO_LAST) begin
          err_next   = 1'b1;
          state_next = IDLE;
          owner_next = OWN_NONE;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + 8'd1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // One read-return path per read client: index 0 is audio, 1 is video.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : read_port
      localparam logic [1:0] OWN_ID = (gi == 0) ? OWN_A : OWN_V;
      logic [15:0] data_reg;
      logic        valid_reg;
      logic        hit;

      assign hit = rd_capture && (owner_reg == OWN_ID);

      always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
          data_reg  <= '0;
          valid_reg <= 1'b0;
        end else begin
          valid_reg <= hit;
          if (hit) begin
            data_reg <= bus.mem_rdata;
          end
        end
      end

      if (gi == 0) begin : audio_out
        assign bus.a_data     = data_reg;
        assign bus.a_valid    = valid_reg;
        assign bus.a_op_begun = bus.mem_op_begun && (owner_reg == OWN_ID);
      end else begin : video_out
        assign bus.v_data     = data_reg;
        assign bus.v_valid    = valid_reg;
        assign bus.v_op_begun = bus.mem_op_begun && (owner_reg == OWN_ID);
      end
    end
  endgenerate

  assign bus.ld_op_begun    = bus.mem_op_begun && (owner_reg == OWN_LD);
  assign bus.mem_req        = mem_req_reg;
  assign bus.mem_we         = mem_we_reg;
  assign bus.mem_address    = mem_address_reg;
  assign bus.mem_wdata      = mem_wdata_reg;
  assign bus.owner          = owner_reg;
  assign bus.rd_timeout_err = err_reg;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: a RAM responder model, a scoreboard of expected
// grants and read returns, and one task per scenario.
module tb_ram_port_arbiter;
  logic clk50;
  logic reset_n;

  ram_port_arbiter_if bus ();

  ram_port_arbiter #(
    .MAX_WAIT   (8),
    .RD_TIMEOUT (4)
  ) dut (
    .clk50   (clk50),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk50 = 1'b0;
  always #5 clk50 = ~clk50;

  typedef struct packed {
    logic [1:0]  owner;
    logic        we;
    logic [24:0] addr;
    logic [15:0] wdata;
  } grant_t;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  grant_t      exp_grant[$];
  logic [15:0] exp_a[$];
  logic [15:0] exp_v[$];
  logic [15:0] rdata_q[$];

  // Responder controls
  bit resp_en    = 1'b1;
  int accept_lat = 0;
  int rv_lat     = 1;
  bit rv_drop    = 1'b0;
  bit stray_rv   = 1'b0;

  task automatic tick();
    @(negedge clk50);
    #1;
  endtask

  // RAM model: accepts after accept_lat cycles of mem_req, returns read data
  // rv_lat cycles after acceptance unless rv_drop is set.
  task automatic responder();
    int acc_cnt = 0;
    int rv_cnt  = 0;
    forever begin
      @(negedge clk50);
      if (!resp_en) begin
        bus.mem_op_begun = 1'b0;
        bus.mem_rvalid   = stray_rv;
        bus.mem_rdata    = 16'hDEAD;
        acc_cnt = 0;
        rv_cnt  = 0;
      end else begin
        bus.mem_op_begun = 1'b0;
        bus.mem_rvalid   = 1'b0;
        if (rv_cnt != 0) begin
          rv_cnt--;
          if (rv_cnt == 0 && !rv_drop && rdata_q.size() > 0) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = rdata_q.pop_front();
          end
        end
        if (bus.mem_req === 1'b1) begin
          if (acc_cnt >= accept_lat) begin
            bus.mem_op_begun = 1'b1;
            acc_cnt = 0;
            if (bus.mem_we === 1'b0) rv_cnt = rv_lat;
          end else begin
            acc_cnt++;
          end
        end else begin
          acc_cnt = 0;
        end
      end
    end
  endtask

  task automatic scoreboard_monitor();
    logic [1:0]  prev_owner = 2'd0;
    grant_t      g;
    logic [15:0] e;
    forever begin
      tick();
      if (reset_n === 1'b1) begin
        if (bus.owner !== 2'd0 && prev_owner === 2'd0) begin
          total_cnt++;
          if (exp_grant.size() == 0) begin
            $display("FAIL grant_unexpected: got owner %0d addr %h, expected no grant", bus.owner, bus.mem_address);
          end else begin
            g = exp_grant.pop_front();
            if (bus.owner !== g.owner || bus.mem_we !== g.we || bus.mem_address !== g.addr ||
                (g.we && bus.mem_wdata !== g.wdata) || bus.mem_req !== 1'b1)
              $display("FAIL grant: got owner %0d we %0b addr %h wdata %h req %0b, expected owner %0d we %0b addr %h wdata %h req 1",
                       bus.owner, bus.mem_we, bus.mem_address, bus.mem_wdata, bus.mem_req, g.owner, g.we, g.addr, g.wdata);
            else pass_cnt++;
          end
          $display("grant owner=%0d addr=%h we=%0b", bus.owner, bus.mem_address, bus.mem_we);
        end
        if (bus.a_valid === 1'b1) begin
          total_cnt++;
          if (exp_a.size() == 0) begin
            $display("FAIL a_valid_unexpected: got a_data %h, expected no pulse", bus.a_data);
          end else begin
            e = exp_a.pop_front();
            if (bus.a_data !== e) $display("FAIL a_data: got %h expected %h", bus.a_data, e);
            else pass_cnt++;
          end
          $display("audio read data=%h", bus.a_data);
        end
        if (bus.v_valid === 1'b1) begin
          total_cnt++;
          if (exp_v.size() == 0) begin
            $display("FAIL v_valid_unexpected: got v_data %h, expected no pulse", bus.v_data);
          end else begin
            e = exp_v.pop_front();
            if (bus.v_data !== e) $display("FAIL v_data: got %h expected %h", bus.v_data, e);
            else pass_cnt++;
          end
          $display("video read data=%h", bus.v_data);
        end
      end
      prev_owner = bus.owner;
    end
  endtask

  function automatic logic ack_of(input int who);
    case (who)
      1:       return bus.ld_op_begun;
      2:       return bus.a_op_begun;
      default: return bus.v_op_begun;
    endcase
  endfunction

  task automatic wait_ack(input int who, output int cyc);
    cyc = 0;
    while (ack_of(who) !== 1'b1 && cyc < 30) begin
      tick();
      cyc++;
    end
  endtask

  task automatic wait_drain(output bit empty);
    int cyc = 0;
    while ((exp_a.size() != 0 || exp_v.size() != 0) && cyc < 40) begin
      tick();
      cyc++;
    end
    empty = (exp_a.size() == 0 && exp_v.size() == 0);
  endtask

  task automatic test_reset();
    logic [90:0] obs;
    reset_n = 1'b0;
    bus.ld_we = 1'b0; bus.ld_address = '0; bus.ld_data = '0; bus.ld_done = 1'b0;
    bus.a_rd = 1'b0; bus.a_address = '0; bus.v_rd = 1'b0; bus.v_address = '0;
    repeat (3) tick();
    obs = {bus.owner, bus.mem_we, bus.mem_address, bus.mem_wdata, bus.a_data, bus.v_data,
           bus.a_valid, bus.v_valid, bus.rd_timeout_err};
    total_cnt++;
    if (obs !== '0) $display("FAIL reset_outputs: got %h expected 0", obs);
    else pass_cnt++;
    total_cnt++;
    if (bus.mem_req !== 1'b0) $display("FAIL reset_mem_req: got %b expected 0", bus.mem_req);
    else pass_cnt++;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_loader_write();
    int cyc;
    accept_lat = 3;
    bus.ld_done = 1'b0;
    bus.ld_we = 1'b1; bus.ld_address = 25'h000123; bus.ld_data = 16'hBEEF;
    exp_grant.push_back('{owner: 2'd1, we: 1'b1, addr: 25'h000123, wdata: 16'hBEEF});
    tick();
    total_cnt++;
    if (bus.mem_req !== 1'b1) $display("FAIL ldw_req_latency: got mem_req %b expected 1", bus.mem_req);
    else pass_cnt++;
    wait_ack(1, cyc);
    total_cnt++;
    if (bus.ld_op_begun !== 1'b1 || cyc != 3)
      $display("FAIL ldw_ack: got ack %b after %0d cycles expected 1 after 3", bus.ld_op_begun, cyc);
    else pass_cnt++;
    bus.ld_we = 1'b0;
    tick();
    total_cnt++;
    if (bus.ld_op_begun !== 1'b0 || bus.owner !== 2'd0 || bus.mem_req !== 1'b0)
      $display("FAIL ldw_done: got ack %b owner %0d req %b expected 0 0 0", bus.ld_op_begun, bus.owner, bus.mem_req);
    else pass_cnt++;
    $display("loader write addr=000123 data=beef complete");
  endtask

  task automatic test_ld_done_in_grant();
    int cyc;
    int req_seen = 0;
    accept_lat = 2;
    bus.ld_we = 1'b1; bus.ld_address = 25'h0ABCDE; bus.ld_data = 16'h1234;
    exp_grant.push_back('{owner: 2'd1, we: 1'b1, addr: 25'h0ABCDE, wdata: 16'h1234});
    tick();
    bus.ld_done = 1'b1;
    wait_ack(1, cyc);
    total_cnt++;
    if (bus.ld_op_begun !== 1'b1) $display("FAIL lddone_ack: got %b expected 1", bus.ld_op_begun);
    else pass_cnt++;
    bus.ld_we = 1'b0;
    tick();
    total_cnt++;
    if (bus.owner !== 2'd0) $display("FAIL lddone_owner: got %0d expected 0", bus.owner);
    else pass_cnt++;
    bus.ld_we = 1'b1;
    repeat (5) begin
      tick();
      if (bus.mem_req === 1'b1 || bus.ld_op_begun === 1'b1) req_seen++;
    end
    bus.ld_we = 1'b0;
    total_cnt++;
    if (req_seen != 0) $display("FAIL ld_ignored: got %0d active cycles expected 0", req_seen);
    else pass_cnt++;
    $display("loader write during ld_done rise complete");
  endtask

  task automatic test_blocked_read();
    int cyc;
    int req_seen = 0;
    bit empty;
    accept_lat = 0; rv_lat = 2;
    bus.ld_done = 1'b0;
    bus.a_rd = 1'b1; bus.a_address = 25'h0000AA;
    repeat (20) begin
      tick();
      if (bus.mem_req !== 1'b0) req_seen++;
    end
    total_cnt++;
    if (req_seen != 0) $display("FAIL blocked_req: got %0d cycles with mem_req expected 0", req_seen);
    else pass_cnt++;
    exp_grant.push_back('{owner: 2'd2, we: 1'b0, addr: 25'h0000AA, wdata: 16'h0});
    exp_a.push_back(16'hC0DE);
    rdata_q.push_back(16'hC0DE);
    bus.ld_done = 1'b1;
    tick();
    total_cnt++;
    if (bus.owner !== 2'd2) $display("FAIL blocked_grant: got owner %0d expected 2", bus.owner);
    else pass_cnt++;
    wait_ack(2, cyc);
    bus.a_rd = 1'b0;
    wait_drain(empty);
    total_cnt++;
    if (!empty) $display("FAIL blocked_return: got %0d pending expected 0", exp_a.size());
    else pass_cnt++;
    tick();
  endtask

  task automatic test_audio_read();
    int cyc;
    bit empty;
    rv_lat = 3;
    bus.a_rd = 1'b1; bus.a_address = 25'h1ABCDE;
    exp_grant.push_back('{owner: 2'd2, we: 1'b0, addr: 25'h1ABCDE, wdata: 16'h0});
    exp_a.push_back(16'h5A5A);
    rdata_q.push_back(16'h5A5A);
    wait_ack(2, cyc);
    bus.a_rd = 1'b0;
    wait_drain(empty);
    tick();
    total_cnt++;
    if (!empty || bus.a_data !== 16'h5A5A || bus.a_valid !== 1'b0)
      $display("FAIL audio_read: got a_data %h a_valid %b expected 5a5a 0", bus.a_data, bus.a_valid);
    else pass_cnt++;
    total_cnt++;
    if (bus.v_data !== 16'h0) $display("FAIL v_data_hold: got %h expected 0", bus.v_data);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_starvation();
    int cyc = 0;
    bit empty;
    accept_lat = 0; rv_lat = 1;
    for (int i = 0; i < 3; i++) begin
      exp_grant.push_back('{owner: 2'd2, we: 1'b0, addr: 25'h0000AC, wdata: 16'h0});
      exp_a.push_back(16'(16'h1111 * (i + 1)));
      rdata_q.push_back(16'(16'h1111 * (i + 1)));
    end
    exp_grant.push_back('{owner: 2'd3, we: 1'b0, addr: 25'h0000BB, wdata: 16'h0});
    exp_v.push_back(16'h4444);
    rdata_q.push_back(16'h4444);
    bus.a_rd = 1'b1; bus.a_address = 25'h0000AC;
    bus.v_rd = 1'b1; bus.v_address = 25'h0000BB;
    while (bus.owner !== 2'd3 && cyc < 40) begin
      tick();
      cyc++;
    end
    bus.a_rd = 1'b0;
    total_cnt++;
    if (bus.owner !== 2'd3 || cyc != 10)
      $display("FAIL starve_video_grant: got owner %0d after %0d cycles expected 3 after 10", bus.owner, cyc);
    else pass_cnt++;
    wait_ack(3, cyc);
    bus.v_rd = 1'b0;
    wait_drain(empty);
    total_cnt++;
    if (!empty) $display("FAIL starve_return: got %0d pending expected 0", exp_a.size() + exp_v.size());
    else pass_cnt++;
    // Wait counter cleared: audio wins the next contested cycle
    exp_grant.push_back('{owner: 2'd2, we: 1'b0, addr: 25'h0000AD, wdata: 16'h0});
    exp_a.push_back(16'h5555);
    rdata_q.push_back(16'h5555);
    bus.a_rd = 1'b1; bus.a_address = 25'h0000AD;
    bus.v_rd = 1'b1;
    tick();
    bus.v_rd = 1'b0;
    total_cnt++;
    if (bus.owner !== 2'd2) $display("FAIL vwait_cleared: got owner %0d expected 2", bus.owner);
    else pass_cnt++;
    wait_ack(2, cyc);
    bus.a_rd = 1'b0;
    wait_drain(empty);
    tick();
  endtask

  task automatic test_timeout();
    int cyc;
    int stray = 0;
    bit empty;
    accept_lat = 0; rv_drop = 1'b1;
    bus.a_rd = 1'b1; bus.a_address = 25'h0000EE;
    exp_grant.push_back('{owner: 2'd2, we: 1'b0, addr: 25'h0000EE, wdata: 16'h0});
    wait_ack(2, cyc);
    bus.a_rd = 1'b0;
    repeat (4) tick();
    total_cnt++;
    if (bus.rd_timeout_err !== 1'b0) $display("FAIL tmo_not_early: got %b expected 0", bus.rd_timeout_err);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus.rd_timeout_err !== 1'b1 || bus.owner !== 2'd0)
      $display("FAIL tmo_set: got err %b owner %0d expected 1 0", bus.rd_timeout_err, bus.owner);
    else pass_cnt++;
    rv_drop = 1'b0; resp_en = 1'b0; stray_rv = 1'b1;
    tick();
    stray_rv = 1'b0;
    repeat (3) begin
      tick();
      if (bus.a_valid !== 1'b0 || bus.v_valid !== 1'b0) stray++;
    end
    resp_en = 1'b1;
    total_cnt++;
    if (stray != 0) $display("FAIL tmo_stray_rvalid: got %0d pulses expected 0", stray);
    else pass_cnt++;
    total_cnt++;
    if (bus.rd_timeout_err !== 1'b1) $display("FAIL tmo_sticky: got %b expected 1", bus.rd_timeout_err);
    else pass_cnt++;
    exp_grant.push_back('{owner: 2'd2, we: 1'b0, addr: 25'h0000AF, wdata: 16'h0});
    exp_a.push_back(16'h7777);
    rdata_q.push_back(16'h7777);
    bus.a_rd = 1'b1; bus.a_address = 25'h0000AF;
    tick();
    total_cnt++;
    if (bus.owner !== 2'd2) $display("FAIL tmo_idle_regrant: got owner %0d expected 2", bus.owner);
    else pass_cnt++;
    wait_ack(2, cyc);
    bus.a_rd = 1'b0;
    wait_drain(empty);
    tick();
  endtask

  task automatic test_async_reset();
    logic [90:0] obs;
    resp_en = 1'b0;
    bus.a_rd = 1'b1; bus.a_address = 25'h0000DD;
    exp_grant.push_back('{owner: 2'd2, we: 1'b0, addr: 25'h0000DD, wdata: 16'h0});
    tick();
    tick();
    total_cnt++;
    if (bus.mem_req !== 1'b1) $display("FAIL ar_in_grant: got mem_req %b expected 1", bus.mem_req);
    else pass_cnt++;
    #2;
    reset_n = 1'b0;
    #1;
    total_cnt++;
    if (bus.mem_req !== 1'b0) $display("FAIL ar_mem_req_async: got %b expected 0", bus.mem_req);
    else pass_cnt++;
    obs = {bus.owner, bus.mem_we, bus.mem_address, bus.mem_wdata, bus.a_data, bus.v_data,
           bus.a_valid, bus.v_valid, bus.rd_timeout_err};
    total_cnt++;
    if (obs !== '0) $display("FAIL ar_outputs: got %h expected 0", obs);
    else pass_cnt++;
    bus.a_rd = 1'b0;
    tick();
    reset_n = 1'b1;
    resp_en = 1'b1;
    repeat (4) tick();
    $display("async reset during grant applied");
  endtask

  initial begin
    reset_n = 1'b0;
    bus.mem_op_begun = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata = '0;
    fork
      responder();
      scoreboard_monitor();
    join_none
    test_reset();
    test_loader_write();
    test_ld_done_in_grant();
    test_blocked_read();
    test_audio_read();
    test_starvation();
    test_timeout();
    test_async_reset();
    total_cnt++;
    if (exp_grant.size() != 0 || exp_a.size() != 0 || exp_v.size() != 0 || rdata_q.size() != 0)
      $display("FAIL scoreboard_drain: got %0d/%0d/%0d/%0d left expected 0/0/0/0",
               exp_grant.size(), exp_a.size(), exp_v.size(), rdata_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000 expected earlier finish");
    $fatal(1, "watchdog expired");
  end
endmodule
